// File: rtl/fir_axil_cfg.sv
// fir_axil_cfg: AXI4-Lite control/status registers and host access to the FIR tap BRAM.
// Optional build macro FIR_CFG_DONE_COR_EN makes ap_done clear when ap_ctrl is read.
module fir_axil_cfg #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic                   core_tap_EN,
    input  logic [pADDR_WIDTH-1:0] core_tap_A,
    input  logic                   core_start_ack,
    input  logic                   core_done,
    output logic                   ap_start,
    output logic                   busy,
    output logic [31:0]            data_length,
    output logic [31:0]            tap_num
);

    // Handshakes: a beat transfers on the rising edge where valid and ready are both high;
    // the master holds address/data stable until then, readies and rvalid come from FSM state only.

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(8'h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAPS = pADDR_WIDTH'(8'h14);
    localparam logic [pADDR_WIDTH-1:0] TAP_LO    = pADDR_WIDTH'(8'h80);
    localparam logic [pADDR_WIDTH-1:0] TAP_HI    = pADDR_WIDTH'(8'hFF);
    localparam logic [pADDR_WIDTH-1:0] TAP_MASK  = pADDR_WIDTH'(8'h7F);

    typedef enum logic {W_IDLE, W_ACK} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [pADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [pDATA_WIDTH-1:0] w_data_q, rdata_q, rd_value;
    logic                   rd_bram_pend;
    logic                   ap_done, ap_idle;
    logic                   w_tap, r_tap, bram_wr, rd_stall, start_ok;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= TAP_LO) && (a <= TAP_HI);
    endfunction

    assign w_tap    = is_tap(aw_addr_q);
    assign r_tap    = is_tap(ar_addr_q);
    assign bram_wr  = (w_state == W_ACK) && w_tap && ap_idle;
    // The BRAM has a single port: a host tap write wins and the tap read waits a cycle.
    assign rd_stall = bram_wr && (r_state == R_ADDR) && r_tap;
    assign start_ok = (w_state == W_ACK) && (aw_addr_q == ADDR_CTRL) && w_data_q[0]
                      && ap_idle && !core_done;
    assign busy     = ~ap_idle;
    assign rdata    = rd_bram_pend ? tap_Do : rdata_q;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        r_next = r_state;
        case (w_state)
            W_IDLE:  if (awvalid && wvalid) w_next = W_ACK;
            W_ACK:   w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE:  if (arvalid) r_next = R_ADDR;
            R_ADDR:  if (!rd_stall) r_next = R_DATA;
            R_DATA:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        awready = (w_state == W_ACK);
        wready  = (w_state == W_ACK);
        arready = (r_state == R_ADDR) && !rd_stall;
        rvalid  = (r_state == R_DATA);
        tap_EN  = 1'b0;
        tap_WE  = 4'h0;
        tap_A   = '0;
        tap_Di  = '0;
        if (!ap_idle) begin
            tap_EN = core_tap_EN;
            tap_A  = core_tap_A;
        end else if (bram_wr) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = aw_addr_q & TAP_MASK;
            tap_Di = w_data_q;
        end else if ((r_state == R_ADDR) && r_tap) begin
            tap_EN = 1'b1;
            tap_A  = ar_addr_q & TAP_MASK;
        end
    end

    always_comb begin
        rd_value = '0;
        if (ar_addr_q == ADDR_CTRL)
            rd_value = pDATA_WIDTH'({ap_idle, ap_done, ap_start});
        else if (ar_addr_q == ADDR_LEN)
            rd_value = pDATA_WIDTH'(data_length);
        else if (ar_addr_q == ADDR_TAPS)
            rd_value = pDATA_WIDTH'(tap_num);
        else if (r_tap && !ap_idle)
            rd_value = '1;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            ar_addr_q    <= '0;
            rdata_q      <= '0;
            rd_bram_pend <= 1'b0;
        end else begin
            if ((w_state == W_IDLE) && awvalid && wvalid) begin
                aw_addr_q <= awaddr;
                w_data_q  <= wdata;
            end
            if ((r_state == R_IDLE) && arvalid)
                ar_addr_q <= araddr;
            // BRAM data lands one cycle after the read; capture it so rdata holds until rready.
            if (arready) begin
                rdata_q      <= rd_value;
                rd_bram_pend <= r_tap && ap_idle;
            end else if (rd_bram_pend) begin
                rdata_q      <= tap_Do;
                rd_bram_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            data_length <= '0;
            tap_num     <= '0;
        end else if ((w_state == W_ACK) && ap_idle) begin
            if (aw_addr_q == ADDR_LEN)  data_length <= w_data_q[31:0];
            if (aw_addr_q == ADDR_TAPS) tap_num     <= w_data_q[31:0];
        end
    end

    // core_done outranks a same-cycle host start, so the start is refused via start_ok.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ap_start <= 1'b0;
            ap_done  <= 1'b0;
            ap_idle  <= 1'b1;
        end else begin
            if (core_start_ack) ap_start <= 1'b0;
`ifdef FIR_CFG_DONE_COR_EN
            if (rvalid && rready && (ar_addr_q == ADDR_CTRL)) ap_done <= 1'b0;
`endif
            if (core_done) begin
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
            end
            if (start_ok) begin
                ap_start <= 1'b1;
                ap_idle  <= 1'b0;
                ap_done  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_axil_cfg.sv
// Directed bench for fir_axil_cfg: a spec-level register model checked every cycle,
// plus literal read-back expectations and latency checks on the AXI-Lite channels.
module tb_fir_axil_cfg;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr, tap_A, core_tap_A;
    logic [DW-1:0] wdata, rdata, tap_Di, tap_Do;
    logic [3:0]    tap_WE;
    logic          tap_EN, core_tap_EN, core_start_ack, core_done, ap_start, busy;
    logic [31:0]   data_length, tap_num;

    fir_axil_cfg #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .core_tap_EN(core_tap_EN), .core_tap_A(core_tap_A),
        .core_start_ack(core_start_ack), .core_done(core_done),
        .ap_start(ap_start), .busy(busy), .data_length(data_length), .tap_num(tap_num)
    );

    int n_checks = 0;
    int n_fail = 0;
    int host_act = 0;
    int we_cnt = 0;
    int wait_n;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Environment: 32-word tap BRAM with one-cycle read latency.
    logic [DW-1:0] bram [32];
    always @(posedge clk) begin
        if (tap_EN) begin
            tap_Do <= bram[tap_A[6:2]];
            if (tap_WE == 4'hF) bram[tap_A[6:2]] <= tap_Di;
        end
    end

    // Register model derived from the address map and control rules, advanced on each edge.
    logic          m_start, m_done, m_idle;
    logic [31:0]   m_len, m_taps;
    logic [AW-1:0] m_raddr;
    bit            acc_start;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_start = 0; m_done = 0; m_idle = 1; m_len = 0; m_taps = 0;
        end else begin
            acc_start = 0;
`ifdef FIR_CFG_DONE_COR_EN
            if (rvalid && rready && m_raddr == 12'h000) m_done = 0;
`endif
            if (arvalid && arready) m_raddr = araddr;
            if (awvalid && awready && wvalid && wready && m_idle) begin
                if (awaddr == 12'h010) m_len = wdata;
                else if (awaddr == 12'h014) m_taps = wdata;
                else if (awaddr == 12'h000 && wdata[0] && !core_done) acc_start = 1;
            end
            if (core_start_ack) m_start = 0;
            if (core_done) begin m_done = 1; m_idle = 1; end
            if (acc_start) begin m_start = 1; m_idle = 0; m_done = 0; end
        end
    end

    always @(negedge clk) begin
        if (rst_n && tap_EN && tap_WE == 4'hF) we_cnt++;
    end

    // Compare process: every cycle, against reset values or the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ready", 32'({awready, wready, arready}), 32'd0);
            check("rst_rvalid", 32'(rvalid), 32'd0);
            check("rst_rdata", rdata, 32'd0);
            check("rst_tap", 32'({tap_EN, tap_WE}), 32'd0);
            check("rst_tap_A", 32'(tap_A), 32'd0);
            check("rst_tap_Di", tap_Di, 32'd0);
            check("rst_ctrl", 32'({ap_start, busy}), 32'd0);
            check("rst_cfg", data_length | tap_num, 32'd0);
        end else begin
            check("ap_start", 32'(ap_start), 32'(m_start));
            check("busy", 32'(busy), 32'(!m_idle));
            check("data_length", data_length, m_len);
            check("tap_num", tap_num, m_taps);
            if (!m_idle) begin
                check("busy_tap_EN", 32'(tap_EN), 32'(core_tap_EN));
                check("busy_tap_A", 32'(tap_A), 32'(core_tap_A));
                check("busy_tap_WE", 32'(tap_WE), 32'd0);
            end else if (host_act == 0) begin
                check("idle_tap_EN", 32'(tap_EN), 32'd0);
            end
        end
    end

    task automatic axil_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input string name);
        int n;
        host_act++;
        @(posedge clk); #1;
        awvalid = 1; wvalid = 1; awaddr = addr; wdata = data;
        n = 0;
        do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
        check({name, "_ready"}, 32'({awready, wready}), 32'd3);
        check({name, "_lat"}, 32'(n - 1), 32'd1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        check({name, "_ready_drop"}, 32'({awready, wready}), 32'd0);
        host_act--;
    endtask

    // Pops the expected value the caller pushed; exp_lat<0 skips the rvalid latency check.
    task automatic axil_read(input logic [AW-1:0] addr, input string name,
                             input int exp_lat, input int hold);
        int n;
        logic [DW-1:0] exp;
        host_act++;
        exp = exp_q.pop_front();
        @(posedge clk); #1;
        arvalid = 1; araddr = addr; rready = (hold == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        if (!arready) begin
            check({name, "_arready_timeout"}, 32'(arready), 32'd1);
            arvalid = 0; rready = 0;
        end else begin
            @(posedge clk); #1;
            arvalid = 0;
            do begin @(negedge clk); n++; end while (!rvalid && n < 40);
            check({name, "_rvalid"}, 32'(rvalid), 32'd1);
            check(name, rdata, exp);
            if (exp_lat >= 0) check({name, "_lat"}, 32'(n - 1), 32'(exp_lat));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({name, "_hold"}, rdata, exp);
                check({name, "_hold_rvalid"}, 32'(rvalid), 32'd1);
            end
            if (hold > 0) begin @(posedge clk); #1; rready = 1; end
            @(posedge clk); #1;
            rready = 0;
            @(negedge clk);
            check({name, "_rvalid_drop"}, 32'(rvalid), 32'd0);
        end
        host_act--;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (bram[i]) bram[i] = '0;
        tap_Do = '0;
        rst_n = 0;
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0;
        core_tap_EN = 0; core_tap_A = '0; core_start_ack = 0; core_done = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1;

        // Reset read of ap_ctrl: idle only, rvalid two cycles after arvalid, rdata held.
        exp_q.push_back(32'h4); axil_read(12'h000, "rd_ctrl_reset", 2, 2);

        for (int i = 0; i < 32; i++) axil_write(AW'(12'h080 + 4 * i), DW'(i), "wr_tap");
        @(posedge clk); #1;
        check("tap_we_count", 32'(we_cnt), 32'd32);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(DW'(i)); axil_read(AW'(12'h080 + 4 * i), "rd_tap", 2, 0);
        end

        axil_write(12'h010, 32'd400, "wr_len");
        axil_write(12'h014, 32'd32, "wr_taps");
        axil_write(12'h020, 32'd5, "wr_unmapped");
        axil_write(12'h100, 32'd7, "wr_beyond_window");
        axil_write(12'h000, 32'h0, "wr_start_zero");
        exp_q.push_back(32'd400); axil_read(12'h010, "rd_len", 2, 0);
        exp_q.push_back(32'd32);  axil_read(12'h014, "rd_taps", 2, 0);
        exp_q.push_back(32'd0);   axil_read(12'h020, "rd_unmapped", 2, 0);
        exp_q.push_back(32'd0);   axil_read(12'h100, "rd_beyond_window", 2, 0);
        @(posedge clk); #1;
        check("we_count_unmapped", 32'(we_cnt), 32'd32);
        // Engine requests while idle must not reach the BRAM port.
        core_tap_EN = 1; core_tap_A = 12'h008;
        repeat (3) @(posedge clk);
        #1 core_tap_EN = 0;

        axil_write(12'h000, 32'h1, "wr_start");
        exp_q.push_back(32'h1); axil_read(12'h000, "rd_ctrl_started", 2, 0);
        @(posedge clk); #1 core_start_ack = 1;
        @(posedge clk); #1 core_start_ack = 0;
        exp_q.push_back(32'h0); axil_read(12'h000, "rd_ctrl_busy", 2, 0);

        core_tap_EN = 1; core_tap_A = 12'h00C;
        axil_write(12'h080, 32'h1234, "wr_tap_busy");
        exp_q.push_back(32'hFFFF_FFFF); axil_read(12'h080, "rd_tap_busy", 2, 0);
        axil_write(12'h010, 32'd99, "wr_len_busy");
        axil_write(12'h000, 32'h1, "wr_start_busy");
        @(posedge clk); #1;
        check("we_count_busy", 32'(we_cnt), 32'd32);
        core_tap_EN = 0; core_tap_A = '0;

        // core_done lands in the same cycle as a host start: the start is refused.
        fork
            axil_write(12'h000, 32'h1, "wr_start_vs_done");
            begin
                @(posedge clk); @(posedge clk); #1 core_done = 1;
                @(posedge clk); #1 core_done = 0;
            end
        join
        exp_q.push_back(32'h0); axil_read(12'h080, "rd_tap_after_done", 2, 0);
        exp_q.push_back(32'h6); axil_read(12'h000, "rd_ctrl_done1", 2, 0);
`ifdef FIR_CFG_DONE_COR_EN
        exp_q.push_back(32'h4);
`else
        exp_q.push_back(32'h6);
`endif
        axil_read(12'h000, "rd_ctrl_done2", 2, 0);

        // Simultaneous tap write and tap read: the read is pushed back one cycle.
        exp_q.push_back(32'd2);
        fork
            axil_write(12'h084, 32'h0000_ABCD, "wr_tap_collide");
            axil_read(12'h088, "rd_tap_collide", 3, 0);
        join
        exp_q.push_back(32'h0000_ABCD); axil_read(12'h084, "rd_tap_collided", 2, 0);
        @(posedge clk); #1;
        check("we_count_collide", 32'(we_cnt), 32'd33);

        axil_write(12'h000, 32'h1, "wr_restart");
        exp_q.push_back(32'h1); axil_read(12'h000, "rd_ctrl_restart", 2, 0);

        // Reset while rvalid is held waiting for rready.
        host_act++;
        @(posedge clk); #1;
        arvalid = 1; araddr = 12'h000; rready = 0;
        wait_n = 0;
        do begin @(negedge clk); wait_n++; end while (!arready && wait_n < 20);
        @(posedge clk); #1 arvalid = 0;
        wait_n = 0;
        do begin @(negedge clk); wait_n++; end while (!rvalid && wait_n < 20);
        check("mid_rvalid", 32'(rvalid), 32'd1);
        @(posedge clk); #1 rst_n = 0;
        #1;
        check("rst_rvalid_drop", 32'(rvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ap_start", 32'(ap_start), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'({awready, wready, arready, rvalid}), 32'd0);
        end
        host_act--;
        exp_q.push_back(32'h4); axil_read(12'h000, "rd_ctrl_post_rst", 2, 0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
